// File: rtl/fp_round_packer.sv
// rtl/fp_round_packer.sv - two-stage IEEE-754 round-and-pack with valid/ready handshakes
module fp_round_packer #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   z_s,
    input  logic [EXP_W+1:0]       z_e,
    input  logic [MAN_W+3:0]       z_m,
    input  logic [1:0]             rmode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   z,
    output logic                   flag_ovf,
    output logic                   flag_unf,
    output logic                   flag_inx
);

    localparam int EW   = EXP_W + 2;
    localparam int BIAS = (1 << (EXP_W - 1)) - 1;

    localparam logic signed [EXP_W+1:0] BIAS_X = EW'(BIAS);
    localparam logic signed [EXP_W+1:0] EMIN_X = EW'(1 - BIAS);
    localparam logic        [EXP_W+1:0] ONE_X  = EW'(1);
    localparam logic        [EXP_W-1:0] BIAS_F = EXP_W'(BIAS);
    localparam logic        [EXP_W-1:0] EXP_INF  = {EXP_W{1'b1}};
    localparam logic        [EXP_W-1:0] EXP_MAXF = {{(EXP_W-1){1'b1}}, 1'b0};

    localparam logic [1:0] RM_RNE = 2'd0;
    localparam logic [1:0] RM_RTZ = 2'd1;
    localparam logic [1:0] RM_RUP = 2'd2;
    localparam logic [1:0] RM_RDN = 2'd3;

    // Handshake
    logic v1, v2;
    logic s2_adv;

    assign s2_adv    = !v2 || out_ready;
    assign in_ready  = !v1 || s2_adv;
    assign out_valid = v2;

    // Stage 1: rounding
    logic [MAN_W:0]          m_in;
    logic                    inx_c;
    logic                    up_c;
    logic [MAN_W+1:0]        mr_c;
    logic [MAN_W:0]          m_c;
    logic signed [EXP_W+1:0] e_c;
    logic                    tiny_c;

    assign m_in = z_m[MAN_W+3:3];

    always_comb begin
        inx_c = |z_m[2:0];
        up_c  = 1'b0;
        case (rmode)
            RM_RNE:  up_c = z_m[2] && (z_m[1] || z_m[0] || z_m[3]);
            RM_RTZ:  up_c = 1'b0;
            RM_RUP:  up_c = inx_c && !z_s;
            RM_RDN:  up_c = inx_c && z_s;
            default: up_c = 1'b0;
        endcase
        mr_c = {1'b0, m_in} + {{(MAN_W+1){1'b0}}, up_c};
        if (mr_c[MAN_W+1]) begin
            m_c = mr_c[MAN_W+1:1];
            e_c = $signed(z_e + ONE_X);
        end else begin
            m_c = mr_c[MAN_W:0];
            e_c = $signed(z_e);
        end
        // Out-of-range judgement uses the exponent as presented, before any carry.
        tiny_c = $signed(z_e) < EMIN_X;
    end

    logic                    s1_s;
    logic signed [EXP_W+1:0] s1_e;
    logic [MAN_W:0]          s1_m;
    logic                    s1_inx;
    logic                    s1_tiny;
    logic [1:0]              s1_rmode;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1       <= 1'b0;
            s1_s     <= 1'b0;
            s1_e     <= '0;
            s1_m     <= '0;
            s1_inx   <= 1'b0;
            s1_tiny  <= 1'b0;
            s1_rmode <= RM_RNE;
        end else if (in_ready) begin
            v1 <= in_valid;
            if (in_valid) begin
                s1_s     <= z_s;
                s1_e     <= e_c;
                s1_m     <= m_c;
                s1_inx   <= inx_c;
                s1_tiny  <= tiny_c;
                s1_rmode <= rmode;
            end
        end
    end

    // Stage 2: packing
    logic [EXP_W+MAN_W:0] z_c;
    logic                 ovf_c, unf_c, inx2_c;
    logic                 to_inf;

    always_comb begin
        z_c    = '0;
        ovf_c  = 1'b0;
        unf_c  = 1'b0;
        inx2_c = s1_inx;
        to_inf = (s1_rmode == RM_RNE) ||
                 (s1_rmode == RM_RUP && !s1_s) ||
                 (s1_rmode == RM_RDN && s1_s);
        if (s1_tiny) begin
            z_c    = {s1_s, {(EXP_W+MAN_W){1'b0}}};
            unf_c  = 1'b1;
            inx2_c = 1'b1;
        end else if (s1_m == '0) begin
            z_c = {s1_s, {(EXP_W+MAN_W){1'b0}}};
        end else if (s1_e > BIAS_X) begin
            ovf_c  = 1'b1;
            inx2_c = 1'b1;
            if (to_inf) begin
                z_c = {s1_s, EXP_INF, {MAN_W{1'b0}}};
            end else begin
                z_c = {s1_s, EXP_MAXF, {MAN_W{1'b1}}};
            end
        end else if (s1_e == EMIN_X && !s1_m[MAN_W]) begin
            z_c   = {s1_s, {EXP_W{1'b0}}, s1_m[MAN_W-1:0]};
            unf_c = s1_inx;
        end else begin
            // A subnormal rounded up into the hidden bit lands here with exp field 1.
            z_c = {s1_s, s1_e[EXP_W-1:0] + BIAS_F, s1_m[MAN_W-1:0]};
        end
    end

    logic [EXP_W+MAN_W:0] z_r;
    logic                 ovf_r, unf_r, inx_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2    <= 1'b0;
            z_r   <= '0;
            ovf_r <= 1'b0;
            unf_r <= 1'b0;
            inx_r <= 1'b0;
        end else if (s2_adv) begin
            v2 <= v1;
            if (v1) begin
                z_r   <= z_c;
                ovf_r <= ovf_c;
                unf_r <= unf_c;
                inx_r <= inx2_c;
            end
        end
    end

    assign z        = z_r;
    assign flag_ovf = v2 && ovf_r;
    assign flag_unf = v2 && unf_r;
    assign flag_inx = v2 && inx_r;

endmodule

// File: tb/tb_fp_round_packer.sv
// tb/tb_fp_round_packer.sv - randomized and directed bench for fp_round_packer
module tb_fp_round_packer;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              z_s = 1'b0;
    logic signed [9:0] z_e = '0;
    logic [26:0]       z_m = '0;
    logic [1:0]        rmode = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [31:0]       z;
    logic              flag_ovf, flag_unf, flag_inx;

    int          checks = 0;
    int          failures = 0;
    logic [34:0] sb[$];
    bit          use_dir = 1'b0;
    logic [34:0] dir_exp = '0;
    bit          last_acc = 1'b0;

    fp_round_packer #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .z_s(z_s), .z_e(z_e), .z_m(z_m), .rmode(rmode),
        .out_valid(out_valid), .out_ready(out_ready),
        .z(z), .flag_ovf(flag_ovf), .flag_unf(flag_unf), .flag_inx(flag_inx)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: returns {ovf, unf, inx, z} for a single-precision result.
    function automatic logic [34:0] model(input bit s, input int e, input int unsigned zm, input int rm);
        int unsigned m;
        int unsigned grs;
        bit          inx;
        bit          up;
        int          ee;
        m   = zm >> 3;
        grs = zm & 7;
        inx = (grs != 0);
        case (rm)
            0:       up = (grs > 4) || (grs == 4 && (m % 2) == 1);
            1:       up = 1'b0;
            2:       up = inx && !s;
            default: up = inx && s;
        endcase
        m  = m + up;
        ee = e;
        if (m >= (1 << 24)) begin
            m  = m / 2;
            ee = ee + 1;
        end
        if (e < -126) return {3'b011, s, 31'h0};
        if (m == 0) return {2'b00, inx, s, 31'h0};
        if (ee > 127) begin
            if (rm == 0 || (rm == 2 && !s) || (rm == 3 && s))
                return {3'b101, s, 8'hFF, 23'h0};
            return {3'b101, s, 8'hFE, 23'h7FFFFF};
        end
        if (ee == -126 && m < (1 << 23)) return {1'b0, inx, inx, s, 8'h00, m[22:0]};
        return {2'b00, inx, s, 8'(ee + 127), m[22:0]};
    endfunction

    task automatic cycle();
        logic [34:0] e;
        @(negedge clk);
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check_eq("spurious_out", 64'(out_valid), 64'd0);
            end else begin
                e = sb.pop_front();
                check_eq("result", 64'({flag_ovf, flag_unf, flag_inx, z}), 64'(e));
            end
        end
        if (!out_valid) check_eq("idle_flags", 64'({flag_ovf, flag_unf, flag_inx}), 64'd0);
        last_acc = in_valid && in_ready;
        if (last_acc) sb.push_back(use_dir ? dir_exp : model(z_s, int'(z_e), 32'(z_m), int'(rmode)));
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input bit s, input int e, input logic [26:0] m, input logic [1:0] rm);
        z_s   = s;
        z_e   = 10'(e);
        z_m   = m;
        rmode = rm;
    endtask

    task automatic send_dir(input bit s, input int e, input logic [26:0] m, input logic [1:0] rm,
                            input logic [34:0] expv);
        set_op(s, e, m, rm);
        in_valid  = 1'b1;
        use_dir   = 1'b1;
        dir_exp   = expv;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (last_acc) break;
        end
        check_eq("accept", 64'(last_acc), 64'd1);
        in_valid = 1'b0;
        use_dir  = 1'b0;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (sb.size() == 0) break;
            cycle();
        end
        check_eq("drain", 64'(sb.size()), 64'd0);
    endtask

    task automatic gen_rand();
        int          k;
        int          e;
        logic [26:0] m;
        k = $urandom_range(0, 9);
        if (k == 0)      e = -127 - int'($urandom_range(0, 3));
        else if (k <= 2) e = -126;
        else if (k == 3) e = int'($urandom_range(126, 128));
        else             e = int'($urandom_range(0, 254)) - 126;
        m = 27'($urandom);
        m[26] = 1'b1;
        if (e == -126 && $urandom_range(0, 1) == 1) m[26] = 1'b0;
        if ($urandom_range(0, 7) == 0) m[25:3] = '1;
        set_op(1'($urandom_range(0, 1)), e, m, 2'($urandom_range(0, 3)));
    endtask

    logic [34:0] held;
    int          acc_cnt;

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_z", 64'(z), 64'd0);
        check_eq("rst_flags", 64'({flag_ovf, flag_unf, flag_inx}), 64'd0);
        rst_n = 1'b1;
        #1;
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);

        // Latency of the first operand
        set_op(0, 0, 27'h4000000, 2'd0);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        use_dir   = 1'b1;
        dir_exp   = {3'b000, 32'h3F800000};
        cycle();
        in_valid = 1'b0;
        use_dir  = 1'b0;
        check_eq("lat1_out_valid", 64'(out_valid), 64'd0);
        cycle();
        check_eq("lat2_out_valid", 64'(out_valid), 64'd1);

        send_dir(0,    0, 27'h4000004, 2'd0, {3'b001, 32'h3F800000});
        send_dir(0,    0, 27'h400000C, 2'd0, {3'b001, 32'h3F800002});
        send_dir(0,    0, 27'h7FFFFFF, 2'd0, {3'b001, 32'h40000000});
        send_dir(0,    0, 27'h7FFFFFF, 2'd1, {3'b001, 32'h3FFFFFFF});
        send_dir(0,  128, 27'h4000000, 2'd0, {3'b101, 32'h7F800000});
        send_dir(0,  128, 27'h4000000, 2'd1, {3'b101, 32'h7F7FFFFF});
        send_dir(1,  128, 27'h4000000, 2'd3, {3'b101, 32'hFF800000});
        send_dir(1,  128, 27'h4000000, 2'd2, {3'b101, 32'hFF7FFFFF});
        send_dir(0, -126, 27'h2000000, 2'd0, {3'b000, 32'h00400000});
        send_dir(0, -126, 27'h2000001, 2'd0, {3'b011, 32'h00400000});
        send_dir(0, -126, 27'h3FFFFFF, 2'd0, {3'b001, 32'h00800000});
        send_dir(1, -127, 27'h4000000, 2'd0, {3'b011, 32'h80000000});
        send_dir(0,    0, 27'h0000000, 2'd0, {3'b000, 32'h00000000});
        send_dir(0,    5, 27'h4000001, 2'd2, {3'b001, 32'h42000001});
        drain();

        // Backpressure: capacity of two, output held stable
        out_ready = 1'b0;
        in_valid  = 1'b1;
        acc_cnt   = 0;
        gen_rand();
        cycle();
        acc_cnt += int'(last_acc);
        gen_rand();
        cycle();
        acc_cnt += int'(last_acc);
        gen_rand();
        check_eq("bp_accepts", 64'(acc_cnt), 64'd2);
        check_eq("bp_in_ready", 64'(in_ready), 64'd0);
        check_eq("bp_out_valid", 64'(out_valid), 64'd1);
        held = {flag_ovf, flag_unf, flag_inx, z};
        repeat (3) begin
            cycle();
            check_eq("bp_in_ready_hold", 64'(in_ready), 64'd0);
            check_eq("bp_hold", 64'({flag_ovf, flag_unf, flag_inx, z}), 64'(held));
        end
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            if (last_acc) break;
        end
        check_eq("bp_third_accept", 64'(last_acc), 64'd1);
        drain();

        // Randomized traffic with random backpressure
        in_valid = 1'b0;
        last_acc = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (!in_valid || last_acc) begin
                in_valid = ($urandom_range(0, 9) < 7);
                if (in_valid) gen_rand();
            end
            out_ready = ($urandom_range(0, 9) < 7);
            cycle();
        end
        drain();

        // Reset mid-stream
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            gen_rand();
            cycle();
        end
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_out_valid", 64'(out_valid), 64'd0);
        check_eq("midrst_in_ready", 64'(in_ready), 64'd1);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) begin
            cycle();
            check_eq("midrst_empty", 64'(out_valid), 64'd0);
        end
        send_dir(1, 0, 27'h4000000, 2'd0, {3'b000, 32'hBF800000});
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
